// File: rtl/prga_decrypt_fsm.sv
// RC4 PRGA decryption sequencer: walks an already-shuffled S-box in a single-port RAM and
// XORs the keystream with the encrypted-message ROM into the decrypted-message RAM.
module prga_decrypt_fsm #(
  parameter int MSG_LEN = 32,
  parameter int MSG_AW  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              fin,
  output logic              busy,
  output logic [7:0]        s_addr,
  output logic [7:0]        s_data,
  output logic              s_wren,
  input  logic [7:0]        s_q,
  output logic [MSG_AW-1:0] enc_addr,
  input  logic [7:0]        enc_q,
  output logic [MSG_AW-1:0] dec_addr,
  output logic [7:0]        dec_data,
  output logic              dec_wren
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_RD_SI, ST_CAP_SI, ST_RD_SJ, ST_CAP_SJ, ST_WR_SI,
    ST_WR_SJ, ST_RD_F, ST_CAP_F, ST_WR_DEC, ST_NEXT, ST_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [7:0]        r_i;
  logic [7:0]        r_j;
  logic [7:0]        r_si;
  logic [7:0]        r_sj;
  logic [7:0]        r_pad;
  logic [MSG_AW-1:0] r_k;
  logic [7:0]        w_f_addr;
  logic              w_last;

  // Keystream index; the 8-bit add drops the carry, giving the mod-256 wrap.
  assign w_f_addr = r_si + r_sj;
  assign w_last   = (r_k == MSG_AW'(MSG_LEN - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_next = ST_RD_SI;
      ST_RD_SI:  w_state_next = ST_CAP_SI;
      ST_CAP_SI: w_state_next = ST_RD_SJ;
      ST_RD_SJ:  w_state_next = ST_CAP_SJ;
      ST_CAP_SJ: w_state_next = ST_WR_SI;
      ST_WR_SI:  w_state_next = ST_WR_SJ;
      ST_WR_SJ:  w_state_next = ST_RD_F;
      ST_RD_F:   w_state_next = ST_CAP_F;
      ST_CAP_F:  w_state_next = ST_WR_DEC;
      ST_WR_DEC: w_state_next = ST_NEXT;
      ST_NEXT:   w_state_next = w_last ? ST_DONE : ST_RD_SI;
      ST_DONE:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_i   <= 8'd0;
      r_j   <= 8'd0;
      r_si  <= 8'd0;
      r_sj  <= 8'd0;
      r_pad <= 8'd0;
      r_k   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_i <= 8'd1;
            r_j <= 8'd0;
            r_k <= '0;
          end
        end
        ST_CAP_SI: begin
          r_si <= s_q;
          r_j  <= r_j + s_q;
        end
        ST_CAP_SJ: r_sj  <= s_q;
        ST_CAP_F:  r_pad <= s_q ^ enc_q;
        ST_NEXT: begin
          if (!w_last) begin
            r_k <= r_k + MSG_AW'(1);
            r_i <= r_i + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs: S[i] is written before S[j], so i == j leaves S[i] intact.
  always_comb begin
    fin      = 1'b0;
    busy     = (r_state != ST_IDLE);
    s_addr   = 8'd0;
    s_data   = 8'd0;
    s_wren   = 1'b0;
    enc_addr = '0;
    dec_addr = '0;
    dec_data = 8'd0;
    dec_wren = 1'b0;
    case (r_state)
      ST_RD_SI: s_addr = r_i;
      ST_RD_SJ: s_addr = r_j;
      ST_WR_SI: begin
        s_addr = r_i;
        s_data = r_sj;
        s_wren = 1'b1;
      end
      ST_WR_SJ: begin
        s_addr = r_j;
        s_data = r_si;
        s_wren = 1'b1;
      end
      ST_RD_F: begin
        s_addr   = w_f_addr;
        enc_addr = r_k;
      end
      ST_WR_DEC: begin
        dec_addr = r_k;
        dec_data = r_pad;
        dec_wren = 1'b1;
      end
      ST_DONE: fin = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prga_decrypt_fsm.sv
// Bench for prga_decrypt_fsm: memory models around the DUT, an RC4 PRGA reference
// feeding a decrypted-byte scoreboard, and a timing table for fin/busy.
module tb_prga_decrypt_fsm;

  localparam int MSG_LEN = 32;
  localparam int MSG_AW  = 5;
  localparam int HIST    = 700;

  logic              clk;
  logic              reset;
  logic              start;
  logic              fin;
  logic              busy;
  logic [7:0]        s_addr;
  logic [7:0]        s_data;
  logic              s_wren;
  logic [7:0]        s_q;
  logic [MSG_AW-1:0] enc_addr;
  logic [7:0]        enc_q;
  logic [MSG_AW-1:0] dec_addr;
  logic [7:0]        dec_data;
  logic              dec_wren;

  prga_decrypt_fsm #(.MSG_LEN(MSG_LEN), .MSG_AW(MSG_AW)) dut (
    .clk(clk), .reset(reset), .start(start), .fin(fin), .busy(busy),
    .s_addr(s_addr), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
    .enc_addr(enc_addr), .enc_q(enc_q),
    .dec_addr(dec_addr), .dec_data(dec_data), .dec_wren(dec_wren)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: registered reads, plus a bench load port for S and the ROM.
  logic [7:0] mem_s   [256];
  logic [7:0] mem_enc [MSG_LEN];
  logic [7:0] mem_dec [MSG_LEN];
  logic       ld_en;
  logic [7:0] ld_addr;
  logic [7:0] ld_sdata;
  logic [7:0] ld_edata;

  always @(posedge clk) begin
    s_q   <= mem_s[s_addr];
    enc_q <= mem_enc[enc_addr];
    if (ld_en) begin
      mem_s[ld_addr] <= ld_sdata;
      mem_enc[ld_addr[MSG_AW-1:0]] <= ld_edata;
    end else begin
      if (s_wren) mem_s[s_addr] <= s_data;
      if (dec_wren) mem_dec[dec_addr] <= dec_data;
    end
  end

  typedef struct packed {
    logic [MSG_AW-1:0] addr;
    logic [7:0]        data;
  } sb_t;

  typedef struct {
    int   cyc;
    logic fin;
    logic busy;
  } vec_t;

  sb_t        sb_q[$];
  vec_t       tbl[8];
  logic [7:0] s_img   [256];
  logic [7:0] enc_img [MSG_LEN];
  logic [7:0] sw_s    [256];
  logic [7:0] sw_enc  [MSG_LEN];
  logic       fin_hist  [HIST];
  logic       busy_hist [HIST];
  int         checks;
  int         failures;
  int         cyc;
  int         n_swr;
  int         n_dwr;
  bit         id_mode;
  bit         wrap_mode;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_fin"}, int'(fin), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_s_wren"}, int'(s_wren), 0);
    chk({tag, "_dec_wren"}, int'(dec_wren), 0);
    chk({tag, "_s_addr_data"}, int'({s_addr, s_data}), 0);
    chk({tag, "_enc_dec_addr"}, int'({enc_addr, dec_addr}), 0);
    chk({tag, "_dec_data"}, int'(dec_data), 0);
  endtask

  // Reference RC4 PRGA on the bench copy of S; pushes expected decrypted bytes.
  task automatic model_run(input int nbytes);
    logic [7:0] i;
    logic [7:0] j;
    logic [7:0] t;
    logic [7:0] tmp;
    sb_t        e;
    i = 8'd0;
    j = 8'd0;
    for (int k = 0; k < nbytes; k++) begin
      i = i + 8'd1;
      j = j + sw_s[i];
      tmp = sw_s[i];
      sw_s[i] = sw_s[j];
      sw_s[j] = tmp;
      t = sw_s[i] + sw_s[j];
      e.addr = MSG_AW'(k);
      e.data = sw_s[t] ^ sw_enc[k];
      sb_q.push_back(e);
    end
  endtask

  task automatic load_mems();
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      ld_en    = 1'b1;
      ld_addr  = 8'(a);
      ld_sdata = s_img[a];
      ld_edata = enc_img[a % MSG_LEN];
      sw_s[a]  = s_img[a];
    end
    for (int k = 0; k < MSG_LEN; k++) sw_enc[k] = enc_img[k];
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic rand_perm();
    logic [7:0] tmp;
    int         r;
    for (int a = 0; a < 256; a++) s_img[a] = 8'(a);
    for (int a = 255; a > 0; a--) begin
      r = $urandom_range(a, 0);
      tmp = s_img[a];
      s_img[a] = s_img[r];
      s_img[r] = tmp;
    end
    for (int k = 0; k < MSG_LEN; k++) enc_img[k] = 8'($urandom_range(255, 0));
  endtask

  // One clock: sample at the falling edge, score any decrypted-byte write.
  task automatic tick();
    sb_t e;
    @(negedge clk);
    cyc++;
    if (s_wren) n_swr++;
    if (dec_wren) begin
      n_dwr++;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_dec_write", int'(dec_addr), -1);
      end else begin
        e = sb_q.pop_front();
        $display("dec write cyc=%0d addr=%0d data=0x%02h expected addr=%0d data=0x%02h",
                 cyc, dec_addr, dec_data, e.addr, e.data);
        chk("sb_dec_addr", int'(dec_addr), int'(e.addr));
        chk("sb_dec_data", int'(dec_data), int'(e.data));
      end
    end
    if (cyc < HIST) begin
      fin_hist[cyc]  = fin;
      busy_hist[cyc] = busy;
    end
    if (id_mode && cyc == 21) begin
      chk("id_S1_after_byte1", int'(mem_s[1]), 8'h01);
      chk("id_S2_after_byte1", int'(mem_s[2]), 8'h03);
      chk("id_S3_after_byte1", int'(mem_s[3]), 8'h02);
    end
    if (wrap_mode && cyc == 3) chk("wrap_rd_sj_addr", int'(s_addr), 8'hFF);
    if (wrap_mode && cyc == 7) chk("wrap_rd_f_addr", int'(s_addr), 8'h0F);
  endtask

  task automatic begin_run();
    n_swr = 0;
    n_dwr = 0;
    cyc   = 0;
    for (int c = 0; c < HIST; c++) begin
      fin_hist[c]  = 1'b0;
      busy_hist[c] = 1'b0;
    end
  endtask

  task automatic do_run(input int ncyc);
    begin_run();
    start = 1'b1;
    for (int n = 0; n < ncyc; n++) begin
      tick();
      if (cyc == 1) start = 1'b0;
    end
  endtask

  task automatic apply_table(input string tag, input int exp_fins);
    int nfin;
    for (int n = 0; n < 8; n++) begin
      chk($sformatf("%s_fin@%0d", tag, tbl[n].cyc), int'(fin_hist[tbl[n].cyc]), int'(tbl[n].fin));
      chk($sformatf("%s_busy@%0d", tag, tbl[n].cyc), int'(busy_hist[tbl[n].cyc]), int'(tbl[n].busy));
    end
    nfin = 0;
    for (int c = 0; c < HIST; c++) nfin += int'(fin_hist[c]);
    chk({tag, "_fin_pulses"}, nfin, exp_fins);
  endtask

  task automatic chk_final_s(input string tag);
    int nmis;
    nmis = 0;
    for (int a = 0; a < 256; a++) if (mem_s[a] !== sw_s[a]) nmis++;
    chk({tag, "_S_mismatches"}, nmis, 0);
    chk({tag, "_sb_leftover"}, sb_q.size(), 0);
  endtask

  int w0s;
  int w0d;

  initial begin
    checks    = 0;
    failures  = 0;
    id_mode   = 1'b0;
    wrap_mode = 1'b0;
    tbl[0] = '{1, 1'b0, 1'b1};
    tbl[1] = '{2, 1'b0, 1'b1};
    tbl[2] = '{10, 1'b0, 1'b1};
    tbl[3] = '{11, 1'b0, 1'b1};
    tbl[4] = '{160, 1'b0, 1'b1};
    tbl[5] = '{320, 1'b0, 1'b1};
    tbl[6] = '{321, 1'b1, 1'b1};
    tbl[7] = '{322, 1'b0, 1'b0};
    reset    = 1'b0;
    start    = 1'b0;
    ld_en    = 1'b0;
    ld_addr  = 8'd0;
    ld_sdata = 8'd0;
    ld_edata = 8'd0;

    // Reset raised between edges must clear outputs before any clock edge.
    #1 reset = 1'b1;
    #2 chk_zero_outputs("rst_init");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Identity S, all-zero ciphertext.
    for (int a = 0; a < 256; a++) s_img[a] = 8'(a);
    for (int k = 0; k < MSG_LEN; k++) enc_img[k] = 8'h00;
    load_mems();
    model_run(MSG_LEN);
    id_mode = 1'b1;
    do_run(330);
    id_mode = 1'b0;
    apply_table("id", 1);
    chk("id_dec0", int'(mem_dec[0]), 8'h02);
    chk("id_dec1", int'(mem_dec[1]), 8'h05);
    chk("id_s_wren_pulses", n_swr, 64);
    chk("id_dec_wren_pulses", n_dwr, 32);
    chk_final_s("id");

    // Random permutation S, random ciphertext.
    rand_perm();
    load_mems();
    model_run(MSG_LEN);
    do_run(330);
    apply_table("rnd", 1);
    chk("rnd_s_wren_pulses", n_swr, 64);
    chk("rnd_dec_wren_pulses", n_dwr, 32);
    chk_final_s("rnd");

    // j and si+sj wrap past 0xFF.
    rand_perm();
    s_img[1]    = 8'hFF;
    s_img[8'hFF] = 8'h10;
    load_mems();
    model_run(MSG_LEN);
    wrap_mode = 1'b1;
    do_run(330);
    wrap_mode = 1'b0;
    chk("wrap_dec0", int'(mem_dec[0]), int'(s_img[8'h0F] ^ enc_img[0]));
    chk_final_s("wrap");

    // Reset in cycle 100 (bytes 0..9 finished), then a fresh full run on the modified S.
    rand_perm();
    load_mems();
    model_run(10);
    begin_run();
    start = 1'b1;
    while (cyc < 100) begin
      tick();
      if (cyc == 1) start = 1'b0;
    end
    #2 reset = 1'b1;
    #1 chk_zero_outputs("rst_mid");
    w0s = n_swr;
    w0d = n_dwr;
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("abort_busy_idle", int'(busy), 0);
    chk("abort_s_writes", n_swr - w0s, 0);
    chk("abort_dec_writes", n_dwr - w0d, 0);
    chk_final_s("abort");
    model_run(MSG_LEN);
    do_run(330);
    apply_table("rerun", 1);
    chk("rerun_s_wren_pulses", n_swr, 64);
    chk_final_s("rerun");

    // Stray start pulses mid-run; start held high through DONE re-runs after one IDLE cycle.
    rand_perm();
    load_mems();
    model_run(MSG_LEN);
    model_run(MSG_LEN);
    begin_run();
    start = 1'b1;
    for (int n = 0; n < 660; n++) begin
      tick();
      start = (cyc == 5 || cyc == 200 || (cyc >= 315 && cyc < 323));
    end
    start = 1'b0;
    apply_table("hold", 2);
    chk("hold_busy@323", int'(busy_hist[323]), 1);
    chk("hold_fin@642", int'(fin_hist[642]), 0);
    chk("hold_fin@643", int'(fin_hist[643]), 1);
    chk("hold_busy@644", int'(busy_hist[644]), 0);
    chk("hold_s_wren_pulses", n_swr, 128);
    chk("hold_dec_wren_pulses", n_dwr, 64);
    chk_final_s("hold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prga_decrypt_fsm.md
PRGA_DECRYPT_FSM -- requirements
Module: prga_decrypt_fsm

Interface
REQ-001 SHALL have parameter: MSG_LEN, 32, number of message bytes decrypted per run (max 32).
REQ-002 SHALL have parameter: MSG_AW, 5, width of message-memory addresses.
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: start  input  1  request one decryption run; sampled only in IDLE.
REQ-006 SHALL have port: fin  output  1  one-cycle pulse when the run completes.
REQ-007 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port: s_addr  output  8  working-memory (S) address.
REQ-009 SHALL have port: s_data  output  8  S write data.
REQ-010 SHALL have port: s_wren  output  1  S write enable.
REQ-011 SHALL have port: s_q  input  8  S read data, valid the cycle after s_addr is presented.
REQ-012 SHALL have port: enc_addr  output  MSG_AW  encrypted-message ROM address.
REQ-013 SHALL have port: enc_q  input  8  ROM data, one-cycle read latency.
REQ-014 SHALL have port: dec_addr  output  MSG_AW  decrypted-message RAM address.
REQ-015 SHALL have port: dec_data  output  8  decrypted byte.
REQ-016 SHALL have port: dec_wren  output  1  decrypted-RAM write enable.

Function
REQ-017 SHALL implement RC4 PRGA over the already-shuffled S: for k=0..MSG_LEN-1 {i=i+1; j=j+S[i]; swap S[i],S[j]; dec[k]=S[S[i]+S[j]] XOR enc[k]}, i=j=0 at run start.
REQ-018 SHALL perform all i, j, si+sj arithmetic modulo 256 (8-bit wrap, carry discarded).
REQ-019 SHALL use states and per-state outputs (unlisted outputs 0): IDLE; RD_SI s_addr=i; CAP_SI si<=s_q, j<=j+s_q; RD_SJ s_addr=j; CAP_SJ sj<=s_q; WR_SI s_addr=i, s_data=sj, s_wren=1; WR_SJ s_addr=j, s_data=si, s_wren=1; RD_F s_addr=si+sj, enc_addr=k; CAP_F pad<=s_q XOR enc_q; WR_DEC dec_addr=k, dec_data=pad, dec_wren=1; NEXT; DONE fin=1.
REQ-020 SHALL transition IDLE->RD_SI when start=1 (loading i=1, j=0, k=0), else stay IDLE; each listed state advances to the next in order unconditionally.
REQ-021 SHALL in NEXT go to DONE if k==MSG_LEN-1, else k<=k+1, i<=i+1, go to RD_SI; DONE->IDLE unconditionally.
REQ-022 SHALL take exactly 10 cycles per byte; fin high exactly in the cycle starting 10*MSG_LEN clock edges after the edge that sampled start (cycle 321 for MSG_LEN=32), for one cycle.
REQ-023 SHALL write WR_SI before WR_SJ so that i==j leaves S[i] unchanged.
REQ-024 SHALL ignore start outside IDLE; start held high re-runs after one IDLE cycle, with i=j=0 and S not restored.
REQ-025 SHALL drive outputs as Moore functions of state and internal registers only (no combinational path from s_q/enc_q/start to any output).

Reset
REQ-026 SHALL on reset assertion immediately, irrespective of clk, force state IDLE, i=j=k=si=sj=pad=0, and all outputs 0.
REQ-027 SHALL, on reset mid-run, abandon the run with no further writes; memory contents already written are not restored.
REQ-028 SHALL require a fresh start after reset deassertion before any memory access.

Verification
REQ-029 Reset asserted between edges -> fin, busy, s_wren, dec_wren, all addresses/data = 0 before next clk edge.
REQ-030 S[x]=x, enc all 0x00, start pulse -> dec[0]=0x02, dec[1]=0x05; S[1]=1, S[2]=0x03, S[3]=0x02 after byte 1; fin in cycle 321 only; busy high cycles 1..321.
REQ-031 Random S, random enc, MSG_LEN=32 -> all 32 dec bytes and final S match software RC4 PRGA model; exactly 64 s_wren and 32 dec_wren pulses.
REQ-032 Wrap: S[1]=0xFF, S[0xFF]=0x10 -> j=0xFF, RD_F s_addr=0x0F (0xFF+0x10 mod 256); dec[0]=S[0x0F] XOR enc[0].
REQ-033 Reset asserted at cycle 100 of a run -> outputs 0 immediately, no writes thereafter; later start -> full 321-cycle run.
REQ-034 start pulsed at cycles 5 and 200 of a run -> no effect; start held high through DONE -> second run begins after one IDLE cycle.
